kfps2kb_keycode_fifo: RTL and testbench
=======================================

Name: kfps2kb_keycode_fifo

Overview:
Downstream consumer of the PS/2 keyboard controller's irq/keycode/clear_keycode interface. Each reported keycode is captured into a small show-ahead FIFO, and the controller is acknowledged via clear_keycode. Buffered codes are presented to a host/CPU read port with a level interrupt. This decouples bursty key traffic, such as break sequences and typematic repeats, from slow host polling.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (depth = 2**DEPTH_LOG2 entries, 8 by default)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous active-high reset
kb_irq  input  1  keycode-valid level from keyboard controller
kb_keycode  input  8  keycode from controller (bit7=1 break, 8'hFF error)
kb_clear_keycode  output  1  acknowledge to controller; clears its irq/keycode
read_strobe  input  1  host pop request, one entry per cycle asserted
data_valid  output  1  FIFO non-empty; data_out holds oldest entry
data_out  output  8  oldest buffered keycode (show-ahead)
count  output  DEPTH_LOG2+1  number of buffered entries, 0..DEPTH
host_irq  output  1  level interrupt, equal to data_valid
overflow  output  1  sticky: a keycode was dropped because FIFO was full
kb_error  output  1  sticky: an 8'hFF keycode was captured
status_clear  input  1  clears overflow and kb_error

Behaviour:
- Reset (synchronous, priority over everything):
  - Capture FSM goes to IDLE.
  - Pointers = 0, count = 0.
  - data_valid = 0, data_out = 8'h00, host_irq = 0.
  - kb_clear_keycode = 0, overflow = 0, kb_error = 0.
  - Storage contents are don't-care.
- Capture FSM, two states:
  - IDLE: kb_clear_keycode = 0. If kb_irq = 1, push kb_keycode this edge and go to ACK.
  - ACK: kb_clear_keycode = 1, decoded directly from the state register with no combinational path from inputs. Stay in ACK while kb_irq = 1. Go to IDLE on the first edge where kb_irq = 0.
  - Exactly one push per kb_irq assertion, even if the controller holds irq for several cycles.
  - kb_keycode is not sampled in ACK.
- Latency:
  - kb_irq sampled high at edge N: entry written at edge N, count and data_valid update at edge N, kb_clear_keycode high from edge N.
  - Back-to-back codes: minimum spacing is capture edge, ≥1 ACK cycle, then IDLE.
- FIFO:
  - Circular buffer; read/write pointers are DEPTH_LOG2 bits and wrap from DEPTH-1 to 0.
  - count tracks occupancy.
  - data_out = storage[rd_ptr] when count > 0, else 8'h00.
  - data_valid = (count != 0); host_irq = data_valid.
- Pop: read_strobe = 1 with count > 0 advances rd_ptr at the edge. read_strobe with count = 0 is ignored, with no pointer movement and no error.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full (count = DEPTH), the pop frees the slot and the push is accepted; no overflow.
  - When count = 0, push and pop cannot coincide because the pop is ignored; the new entry appears with count = 1.
- Push when full without pop:
  - Keycode is dropped and storage is unchanged.
  - overflow set to 1.
  - FSM still enters ACK, so the controller is always acknowledged.
- kb_error is set at any edge where a push of 8'hFF is attempted (accepted or dropped). The 8'hFF entry is still stored if space exists.
- status_clear = 1 clears overflow and kb_error at the edge. If a set event occurs on the same edge, set wins (flag = 1).
- Reset mid-ACK: FSM returns to IDLE and kb_clear_keycode drops the following cycle.
  - If the controller's irq is still high after reset, it is captured again as a new code. This is accepted behaviour.
- count never exceeds DEPTH and never underflows.

Test Plan:
- Single make code: reset, kb_irq=1 with kb_keycode=8'h1C held 3 cycles, then drop → one entry; count=1; data_out=8'h1C; data_valid=host_irq=1; kb_clear_keycode high from the capture edge until the edge after kb_irq low; read_strobe 1 cycle → count=0, data_out=8'h00, host_irq=0.
- Break sequence: codes 8'h1C then 8'h9C (two irq pulses, 1 ACK each) → FIFO order 8'h1C, 8'h9C; two pops return them in order; a third pop while empty leaves count=0.
- Fill and overflow (DEPTH=8): push 8'h01..8'h08 → count=8; push 8'h09 → count stays 8, overflow=1, kb_clear_keycode still pulses; pops return 8'h01..8'h08; status_clear → overflow=0.
- Full with simultaneous push/pop: fill with 8 codes, then assert kb_irq(8'h2A) and read_strobe on the same edge → count=8, overflow=0, last entry read out is 8'h2A; pointer wraps correctly across ≥2 full laps.
- Error code and sticky clear: push 8'hFF → kb_error=1, entry 8'hFF stored; status_clear on the same edge as a second 8'hFF push → kb_error remains 1; a later status_clear alone → 0.
- Reset mid-operation: 3 entries buffered and FSM in ACK; assert reset one cycle → count=0, data_valid=0, kb_clear_keycode=0, flags=0; with kb_irq still high after reset, exactly one new entry is captured.

Source files
------------

// File: rtl/kfps2kb_keycode_fifo.sv
// Keycode capture and show-ahead FIFO between a PS/2 keyboard controller and a host.
// Each irq assertion is pushed once and acknowledged; the host pops through read_strobe.
module kfps2kb_keycode_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  kb_irq,
  input  logic [7:0]            kb_keycode,
  output logic                  kb_clear_keycode,
  input  logic                  read_strobe,
  output logic                  data_valid,
  output logic [7:0]            data_out,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  host_irq,
  output logic                  overflow,
  output logic                  kb_error,
  input  logic                  status_clear
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_q, wr_d;
  logic [DEPTH_LOG2-1:0] rd_q, rd_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  kb_error_q, kb_error_d;
  logic [7:0]            mem_q [2**DEPTH_LOG2];

  logic push_req_s, pop_s, full_s, push_ok_s, drop_s, err_hit_s;

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  assign push_req_s = (state_q == ST_IDLE) && kb_irq;
  assign pop_s      = read_strobe && (count_q != '0);
  assign full_s     = (count_q == DEPTH_C);
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign drop_s     = push_req_s && full_s && !pop_s;
  assign err_hit_s  = push_req_s && (kb_keycode == 8'hFF);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (kb_irq)  state_d = ST_ACK;  else state_d = ST_IDLE;
      ST_ACK:  if (!kb_irq) state_d = ST_IDLE; else state_d = ST_ACK;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok_s) wr_d = wr_q + DEPTH_LOG2'(1); else wr_d = wr_q;
    if (pop_s)     rd_d = rd_q + DEPTH_LOG2'(1); else rd_d = rd_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky flags: a set event on the same edge as status_clear wins.
  always_comb begin
    overflow_d = overflow_q;
    kb_error_d = kb_error_q;
    if (drop_s)            overflow_d = 1'b1;
    else if (status_clear) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
    if (err_hit_s)         kb_error_d = 1'b1;
    else if (status_clear) kb_error_d = 1'b0;
    else                   kb_error_d = kb_error_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      kb_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      kb_error_q <= kb_error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok_s && !reset) mem_q[wr_q] <= kb_keycode;
  end

  assign kb_clear_keycode = (state_q == ST_ACK);
  assign data_valid       = (count_q != '0);
  assign host_irq         = (count_q != '0);
  assign data_out         = (count_q != '0) ? mem_q[rd_q] : 8'h00;
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign kb_error         = kb_error_q;

endmodule

// File: tb/tb_kfps2kb_keycode_fifo.sv
// Bench for kfps2kb_keycode_fifo: directed table, hand sequences and random traffic
// compared against a queue-based model of the capture/FIFO behaviour.
module tb_kfps2kb_keycode_fifo;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset, kb_irq, kb_clear_keycode, read_strobe, data_valid;
  logic       host_irq, overflow, kb_error, status_clear;
  logic [7:0] kb_keycode, data_out;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;

  // model state
  logic [7:0] mq[$];
  bit m_ack, m_ovf, m_err;

  typedef struct {
    logic       rst, irq, rd, sclr;
    logic [7:0] code;
    logic [3:0] e_cnt;
    logic [7:0] e_dout;
    logic       e_clr, e_ovf, e_err;
  } vec_t;

  vec_t tbl[19];

  kfps2kb_keycode_fifo #(.DEPTH_LOG2(3)) dut (
    .clock(clock), .reset(reset), .kb_irq(kb_irq), .kb_keycode(kb_keycode),
    .kb_clear_keycode(kb_clear_keycode), .read_strobe(read_strobe),
    .data_valid(data_valid), .data_out(data_out), .count(count),
    .host_irq(host_irq), .overflow(overflow), .kb_error(kb_error),
    .status_clear(status_clear)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic rst, logic irq, logic [7:0] code, logic rd, logic sclr,
                              logic [3:0] c, logic [7:0] d, logic clr, logic ovf, logic err);
    vec_t v;
    v.rst = rst; v.irq = irq; v.code = code; v.rd = rd; v.sclr = sclr;
    v.e_cnt = c; v.e_dout = d; v.e_clr = clr; v.e_ovf = ovf; v.e_err = err;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same edge, compare everything.
  task automatic cyc(logic rst, logic irq, logic [7:0] code, logic rd, logic sclr);
    bit pop;
    logic [7:0] e_dout;
    reset = rst; kb_irq = irq; kb_keycode = code; read_strobe = rd; status_clear = sclr;
    @(posedge clock);
    if (rst) begin
      mq.delete(); m_ack = 0; m_ovf = 0; m_err = 0;
    end else begin
      pop = rd && (mq.size() > 0);
      if (sclr) begin m_ovf = 0; m_err = 0; end
      if (pop) void'(mq.pop_front());
      if (irq && !m_ack) begin
        if (code == 8'hFF) m_err = 1;
        if (mq.size() < DEPTH) mq.push_back(code);
        else m_ovf = 1;
      end
      m_ack = irq;
    end
    #1;
    e_dout = (mq.size() > 0) ? mq[0] : 8'h00;
    checks++;
    if (count !== 4'(mq.size()) || data_valid !== (mq.size() > 0) || host_irq !== (mq.size() > 0) ||
        data_out !== e_dout || kb_clear_keycode !== m_ack || overflow !== m_ovf || kb_error !== m_err) begin
      failures++;
      $display("FAIL model t=%0t: got cnt=%0d dv=%b irq=%b dout=%h clr=%b ovf=%b err=%b expected cnt=%0d dout=%h clr=%b ovf=%b err=%b",
               $time, count, data_valid, host_irq, data_out, kb_clear_keycode, overflow, kb_error,
               mq.size(), e_dout, m_ack, m_ovf, m_err);
    end
  endtask

  initial begin
    logic [7:0] last_rd;
    bit irq_r;
    reset = 1'b1; kb_irq = 1'b0; kb_keycode = 8'h00; read_strobe = 1'b0; status_clear = 1'b0;

    //             rst irq code   rd sclr cnt dout  clr ovf err
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h1C, 0, 0, 4'd1, 8'h1C, 1, 0, 0);
    tbl[2]  = mk(0, 1, 8'h1C, 0, 0, 4'd1, 8'h1C, 1, 0, 0);
    tbl[3]  = mk(0, 1, 8'h1C, 0, 0, 4'd1, 8'h1C, 1, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 0, 0, 4'd1, 8'h1C, 0, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 0, 4'd0, 8'h00, 0, 0, 0);
    tbl[6]  = mk(0, 1, 8'h1C, 0, 0, 4'd1, 8'h1C, 1, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 0, 0, 4'd1, 8'h1C, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8'h9C, 0, 0, 4'd2, 8'h1C, 1, 0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 0, 0, 4'd2, 8'h1C, 0, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 0, 4'd1, 8'h9C, 0, 0, 0);
    tbl[11] = mk(0, 0, 8'h00, 1, 0, 4'd0, 8'h00, 0, 0, 0);
    tbl[12] = mk(0, 0, 8'h00, 1, 0, 4'd0, 8'h00, 0, 0, 0);
    tbl[13] = mk(0, 1, 8'hFF, 0, 0, 4'd1, 8'hFF, 1, 0, 1);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 4'd1, 8'hFF, 0, 0, 1);
    tbl[15] = mk(0, 1, 8'hFF, 0, 1, 4'd2, 8'hFF, 1, 0, 1);
    tbl[16] = mk(0, 0, 8'h00, 0, 1, 4'd2, 8'hFF, 0, 0, 0);
    tbl[17] = mk(0, 0, 8'h00, 1, 0, 4'd1, 8'hFF, 0, 0, 0);
    tbl[18] = mk(0, 0, 8'h00, 1, 0, 4'd0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst, tbl[i].irq, tbl[i].code, tbl[i].rd, tbl[i].sclr);
      checks++;
      if (count !== tbl[i].e_cnt || data_out !== tbl[i].e_dout || kb_clear_keycode !== tbl[i].e_clr ||
          overflow !== tbl[i].e_ovf || kb_error !== tbl[i].e_err || data_valid !== (tbl[i].e_cnt != 0)) begin
        failures++;
        $display("FAIL table[%0d]: got cnt=%0d dout=%h clr=%b ovf=%b err=%b expected cnt=%0d dout=%h clr=%b ovf=%b err=%b",
                 i, count, data_out, kb_clear_keycode, overflow, kb_error,
                 tbl[i].e_cnt, tbl[i].e_dout, tbl[i].e_clr, tbl[i].e_ovf, tbl[i].e_err);
      end
    end

    // Fill to DEPTH, then one more push is dropped but still acknowledged.
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'(i), 0, 0);
      cyc(0, 0, 8'h00, 0, 0);
    end
    chk("fill_count", count, 8);
    cyc(0, 1, 8'h09, 0, 0);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_ack", kb_clear_keycode, 1);
    cyc(0, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", data_out, i);
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("drain_empty", count, 0);
    chk("ovf_sticky", overflow, 1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("ovf_clear", overflow, 0);

    // Full FIFO with simultaneous push/pop, looping the pointers twice.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 8'h40 + 8'(i), 0, 0);
      cyc(0, 0, 8'h00, 0, 0);
    end
    for (int j = 0; j < 16; j++) begin
      cyc(0, 1, (j == 15) ? 8'h2A : 8'h50 + 8'(j), 1, 0);
      chk("full_pp_count", count, 8);
      chk("full_pp_ovf", overflow, 0);
      cyc(0, 0, 8'h00, 0, 0);
    end
    chk("full_pp_head", data_out, 8'h58);
    last_rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last_rd = data_out;
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("full_pp_last", last_rd, 8'h2A);
    chk("full_pp_empty", count, 0);

    // Reset while acknowledging with 3 entries and flags set; irq stays high across it.
    cyc(0, 1, 8'hFF, 0, 0); cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h12, 0, 0); cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h13, 0, 0);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_clr", kb_clear_keycode, 1);
    cyc(1, 1, 8'h13, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_clr", kb_clear_keycode, 0);
    chk("rst_err", kb_error, 0);
    chk("rst_dout", data_out, 8'h00);
    cyc(0, 1, 8'h33, 0, 0);
    chk("post_rst_cap", count, 1);
    chk("post_rst_dout", data_out, 8'h33);
    cyc(0, 1, 8'h33, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("post_rst_once", count, 1);

    // Random traffic against the model.
    irq_r = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) irq_r = !irq_r;
      cyc(($urandom_range(0, 299) == 0), irq_r,
          ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
